// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one SDRAM controller command port between two
//               requesters (A: memory test engine, B: secondary master) and
//               schedules auto-refresh. One transaction outstanding at a time.
//               Priority: urgent refresh, round-robin A/B, idle refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int ADDR_W           = 24,
    parameter int DATA_W           = 16,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_URGENT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    // port A
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    // port B
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    // controller command/response
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic [1:0]        mem_cmd_op,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    // refresh status
    output logic [3:0]        refresh_pending,
    output logic              refresh_overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_TIMER_W      = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_RELOAD = c_TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE    = c_TIMER_W'(1);
    localparam logic [3:0]          c_URGENT       = 4'(REFRESH_URGENT);
    localparam logic [3:0]          c_PEND_MAX     = 4'hF;

    localparam logic [1:0] c_OP_READ    = 2'b00;
    localparam logic [1:0] c_OP_WRITE   = 2'b01;
    localparam logic [1:0] c_OP_REFRESH = 2'b10;

    localparam logic [1:0] c_OWN_A   = 2'd0;
    localparam logic [1:0] c_OWN_B   = 2'd1;
    localparam logic [1:0] c_OWN_REF = 2'd2;

    localparam logic c_GRANT_A = 1'b0;
    localparam logic c_GRANT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t              r_state,        w_state_nxt;
    logic [1:0]          r_owner,        w_owner_nxt;
    logic                r_last_grant,   w_last_grant_nxt;
    logic                r_cmd_valid,    w_cmd_valid_nxt;
    logic [1:0]          r_cmd_op,       w_cmd_op_nxt;
    logic [ADDR_W-1:0]   r_cmd_addr,     w_cmd_addr_nxt;
    logic [DATA_W-1:0]   r_cmd_wdata,    w_cmd_wdata_nxt;
    logic                r_a_ack,        w_a_ack_nxt;
    logic                r_b_ack,        w_b_ack_nxt;
    logic                r_a_done,       w_a_done_nxt;
    logic                r_b_done,       w_b_done_nxt;
    logic [DATA_W-1:0]   r_a_rdata,      w_a_rdata_nxt;
    logic [DATA_W-1:0]   r_b_rdata,      w_b_rdata_nxt;
    logic [c_TIMER_W-1:0] r_timer,       w_timer_nxt;
    logic [3:0]          r_pending,      w_pending_nxt;
    logic                r_overflow,     w_overflow_nxt;

    logic w_tick;
    logic w_ref_hs;
    logic w_urgent;
    logic w_grant_ref;
    logic w_pick_a;

    // Arbitration decisions: urgent refresh beats requesters, idle refresh
    // only runs when neither port is asking. On a tie the port that did not
    // win last time is chosen.
    assign w_urgent    = (r_pending >= c_URGENT);
    assign w_grant_ref = w_urgent || (!a_req && !b_req && (r_pending != 4'd0));
    assign w_pick_a    = a_req && (!b_req || (r_last_grant == c_GRANT_B));

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // Holds the arbitration phase; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and next-output logic
    // ------------------------------------------------------------------------
    // Selects a winner in IDLE, holds the command until accepted, then waits
    // for the single completion of that command.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_cmd_valid_nxt  = r_cmd_valid;
        w_cmd_op_nxt     = r_cmd_op;
        w_cmd_addr_nxt   = r_cmd_addr;
        w_cmd_wdata_nxt  = r_cmd_wdata;
        w_a_ack_nxt      = 1'b0;
        w_b_ack_nxt      = 1'b0;
        w_a_done_nxt     = 1'b0;
        w_b_done_nxt     = 1'b0;
        w_a_rdata_nxt    = r_a_rdata;
        w_b_rdata_nxt    = r_b_rdata;
        w_ref_hs         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_ref) begin
                    w_owner_nxt     = c_OWN_REF;
                    w_cmd_op_nxt    = c_OP_REFRESH;
                    w_cmd_addr_nxt  = '0;
                    w_cmd_wdata_nxt = '0;
                    w_cmd_valid_nxt = 1'b1;
                    w_state_nxt     = ST_ISSUE;
                end else if (w_pick_a) begin
                    w_owner_nxt      = c_OWN_A;
                    w_last_grant_nxt = c_GRANT_A;
                    w_cmd_op_nxt     = a_we ? c_OP_WRITE : c_OP_READ;
                    w_cmd_addr_nxt   = a_addr;
                    w_cmd_wdata_nxt  = a_wdata;
                    w_cmd_valid_nxt  = 1'b1;
                    w_state_nxt      = ST_ISSUE;
                end else if (b_req) begin
                    w_owner_nxt      = c_OWN_B;
                    w_last_grant_nxt = c_GRANT_B;
                    w_cmd_op_nxt     = b_we ? c_OP_WRITE : c_OP_READ;
                    w_cmd_addr_nxt   = b_addr;
                    w_cmd_wdata_nxt  = b_wdata;
                    w_cmd_valid_nxt  = 1'b1;
                    w_state_nxt      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (r_cmd_valid && mem_cmd_ready) begin
                    w_cmd_valid_nxt = 1'b0;
                    w_state_nxt     = ST_WAIT;
                    case (r_owner)
                        c_OWN_A: w_a_ack_nxt = 1'b1;
                        c_OWN_B: w_b_ack_nxt = 1'b1;
                        default: w_ref_hs    = 1'b1;
                    endcase
                end
            end

            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = ST_IDLE;
                    case (r_owner)
                        c_OWN_A: begin
                            w_a_done_nxt = 1'b1;
                            if (r_cmd_op == c_OP_READ) begin
                                w_a_rdata_nxt = mem_rsp_rdata;
                            end
                        end
                        c_OWN_B: begin
                            w_b_done_nxt = 1'b1;
                            if (r_cmd_op == c_OP_READ) begin
                                w_b_rdata_nxt = mem_rsp_rdata;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command and requester output registers
    // ------------------------------------------------------------------------
    // Every externally visible signal comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= c_OWN_A;
            r_last_grant <= c_GRANT_B;
            r_cmd_valid  <= 1'b0;
            r_cmd_op     <= c_OP_READ;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_a_done     <= 1'b0;
            r_b_done     <= 1'b0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_cmd_op     <= w_cmd_op_nxt;
            r_cmd_addr   <= w_cmd_addr_nxt;
            r_cmd_wdata  <= w_cmd_wdata_nxt;
            r_a_ack      <= w_a_ack_nxt;
            r_b_ack      <= w_b_ack_nxt;
            r_a_done     <= w_a_done_nxt;
            r_b_done     <= w_b_done_nxt;
            r_a_rdata    <= w_a_rdata_nxt;
            r_b_rdata    <= w_b_rdata_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Refresh bookkeeping
    // ------------------------------------------------------------------------
    // Timer ticks add a pending refresh, accepted refresh commands remove one;
    // both in one cycle cancel out. A tick arriving at the ceiling is lost and
    // flagged.
    always_comb begin
        w_tick         = (r_timer == '0);
        w_timer_nxt    = w_tick ? c_TIMER_RELOAD : (r_timer - c_TIMER_ONE);
        w_pending_nxt  = r_pending;
        w_overflow_nxt = r_overflow;
        if (w_tick && !w_ref_hs) begin
            if (r_pending == c_PEND_MAX) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_pending_nxt = r_pending + 4'd1;
            end
        end else if (!w_tick && w_ref_hs && (r_pending != 4'd0)) begin
            w_pending_nxt = r_pending - 4'd1;
        end
    end

    // Refresh timer, pending count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer    <= c_TIMER_RELOAD;
            r_pending  <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign a_ack            = r_a_ack;
    assign a_done           = r_a_done;
    assign a_rdata          = r_a_rdata;
    assign b_ack            = r_b_ack;
    assign b_done           = r_b_done;
    assign b_rdata          = r_b_rdata;
    assign mem_cmd_valid    = r_cmd_valid;
    assign mem_cmd_op       = r_cmd_op;
    assign mem_cmd_addr     = r_cmd_addr;
    assign mem_cmd_wdata    = r_cmd_wdata;
    assign refresh_pending  = r_pending;
    assign refresh_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Directed bench for sdram_port_arbiter with a small controller
//               model and an independent refresh-count reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          a_req, a_we, a_ack, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack, b_done;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_cmd_valid, mem_cmd_ready;
    logic [1:0]    mem_cmd_op;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_rdata;
    logic [3:0]    refresh_pending;
    logic          refresh_overflow;

    sdram_port_arbiter #(
        .ADDR_W           (AW),
        .DATA_W           (DW),
        .REFRESH_INTERVAL (10),
        .REFRESH_URGENT   (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .a_req            (a_req),
        .a_we             (a_we),
        .a_addr           (a_addr),
        .a_wdata          (a_wdata),
        .a_ack            (a_ack),
        .a_done           (a_done),
        .a_rdata          (a_rdata),
        .b_req            (b_req),
        .b_we             (b_we),
        .b_addr           (b_addr),
        .b_wdata          (b_wdata),
        .b_ack            (b_ack),
        .b_done           (b_done),
        .b_rdata          (b_rdata),
        .mem_cmd_valid    (mem_cmd_valid),
        .mem_cmd_ready    (mem_cmd_ready),
        .mem_cmd_op       (mem_cmd_op),
        .mem_cmd_addr     (mem_cmd_addr),
        .mem_cmd_wdata    (mem_cmd_wdata),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_rdata    (mem_rsp_rdata),
        .refresh_pending  (refresh_pending),
        .refresh_overflow (refresh_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Knobs written by the main sequence, read by the controller model
    bit ready_en    = 1'b0;
    int rsp_delay   = 1;
    int inject_req  = 0;
    bit track       = 1'b0;

    // Written only by the controller model / monitor
    int          inject_seen = 0;
    int          cd          = -1;
    int          acc_cnt     = 0;
    logic [DW-1:0] pend_data = '0;
    int          cyc         = 0;
    int          m_pend      = 0;
    bit          m_ovf       = 1'b0;
    bit          model_ok    = 1'b0;
    int          pend_err    = 0;
    int          err_obs     = 0;
    int          err_exp     = 0;
    int          coinc       = 0;
    int          n_a_ack = 0, n_b_ack = 0, n_a_done = 0, n_b_done = 0;
    int          max_pend    = 0;
    bit          urg_flag    = 1'b0;
    int          urg_bad     = 0;
    int          urg_hits    = 0;
    bit          prev_valid  = 1'b0;

    // Controller model plus reference refresh counter, acting 1ns after each
    // falling edge so everything it drives is stable at the next rising edge.
    initial begin
        mem_cmd_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            bit tick, hs;
            @(negedge clk);
            #1;
            if (model_ok) begin
                if ((int'(refresh_pending) != m_pend) || (refresh_overflow !== m_ovf)) begin
                    pend_err++;
                    err_obs = int'(refresh_pending);
                    err_exp = m_pend;
                end
            end
            if (a_ack)  n_a_ack++;
            if (b_ack)  n_b_ack++;
            if (a_done) n_a_done++;
            if (b_done) n_b_done++;
            if (track) begin
                if (int'(refresh_pending) > max_pend) max_pend = int'(refresh_pending);
                if (mem_cmd_valid && !prev_valid && urg_flag) begin
                    if (mem_cmd_op !== 2'b10) urg_bad++;
                    else                      urg_hits++;
                    urg_flag = 1'b0;
                end
                if ((refresh_pending >= 4'd4) && !(mem_cmd_valid && (mem_cmd_op == 2'b10)))
                    urg_flag = 1'b1;
            end else begin
                max_pend = 0;
                urg_flag = 1'b0;
            end
            prev_valid = mem_cmd_valid;

            mem_rsp_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = pend_data;
                    cd = -1;
                end
            end
            if (inject_req != inject_seen) begin
                inject_seen   = inject_req;
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = 16'hDEAD;
            end
            mem_cmd_ready = ready_en;

            if (rst) begin
                cd       = -1;
                acc_cnt  = 0;
                cyc      = 0;
                m_pend   = 0;
                m_ovf    = 1'b0;
                model_ok = 1'b1;
            end else begin
                hs = mem_cmd_valid && mem_cmd_ready && (mem_cmd_op == 2'b10);
                if (mem_cmd_valid && mem_cmd_ready) begin
                    acc_cnt++;
                    pend_data = 16'(32'h1111 * acc_cnt);
                    cd = rsp_delay;
                end
                cyc++;
                tick = ((cyc % 10) == 0);
                if (tick && hs) begin
                    coinc++;
                end else if (tick) begin
                    if (m_pend == 15) m_ovf = 1'b1;
                    else              m_pend++;
                end else if (hs) begin
                    m_pend--;
                end
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        step(2);
    endtask

    // Global time limit so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "time limit reached");
    end

    // Directed sequence
    initial begin
        int snap_a_ack, snap_b_ack, snap_a_done, snap_b_done;
        int ndone;
        bit found;
        logic [1:0]    exp_owner [4];
        logic [DW-1:0] exp_data  [4];

        exp_owner[0] = 2'b10; exp_owner[1] = 2'b01; exp_owner[2] = 2'b10; exp_owner[3] = 2'b01;
        exp_data[0]  = 16'h1111; exp_data[1] = 16'h2222; exp_data[2] = 16'h3333; exp_data[3] = 16'h4444;

        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        step(3);

        // ---- reset values ----
        check("rst valid",    32'(mem_cmd_valid),    32'd0);
        check("rst a_ack",    32'(a_ack),            32'd0);
        check("rst b_done",   32'(b_done),           32'd0);
        check("rst pending",  32'(refresh_pending),  32'd0);
        check("rst overflow", 32'(refresh_overflow), 32'd0);
        check("rst cmd_addr", 32'(mem_cmd_addr),     32'd0);
        check("rst a_rdata",  32'(a_rdata),          32'd0);

        // ---- single A write ----
        ready_en = 1'b1; rsp_delay = 2;
        a_req = 1'b1; a_we = 1'b1; a_addr = 24'h000123; a_wdata = 16'hBEEF;
        snap_b_ack = n_b_ack; snap_b_done = n_b_done;
        rst = 1'b0;
        step(1);
        check("t1 valid",  32'(mem_cmd_valid), 32'd1);
        check("t1 op",     32'(mem_cmd_op),    32'd1);
        check("t1 addr",   32'(mem_cmd_addr),  32'h000123);
        check("t1 wdata",  32'(mem_cmd_wdata), 32'hBEEF);
        check("t1 early ack", 32'(a_ack),      32'd0);
        step(1);
        check("t1 a_ack",     32'(a_ack),         32'd1);
        check("t1 valid drop", 32'(mem_cmd_valid), 32'd0);
        a_req = 1'b0;
        step(1);
        check("t1 ack pulse", 32'(a_ack),  32'd0);
        check("t1 early done", 32'(a_done), 32'd0);
        step(1);
        check("t1 a_done",      32'(a_done),  32'd1);
        check("t1 write no rdata", 32'(a_rdata), 32'd0);
        step(1);
        check("t1 done pulse", 32'(a_done), 32'd0);
        step(2);
        check("t1 b_ack count",  32'(n_b_ack - snap_b_ack),   32'd0);
        check("t1 b_done count", 32'(n_b_done - snap_b_done), 32'd0);

        // ---- A and B reads in round robin ----
        do_reset();
        rst = 1'b0; ready_en = 1'b1; rsp_delay = 1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 24'h00000A;
        b_req = 1'b1; b_we = 1'b0; b_addr = 24'h00000B;
        ndone = 0;
        for (int i = 0; (i < 40) && (ndone < 4); i++) begin
            step(1);
            if (a_done || b_done) begin
                check("t2 owner", 32'({a_done, b_done}), 32'(exp_owner[ndone]));
                check("t2 rdata", 32'((exp_owner[ndone] == 2'b10) ? a_rdata : b_rdata), 32'(exp_data[ndone]));
                if (ndone >= 1)
                    check("t2 other rdata held",
                          32'((exp_owner[ndone] == 2'b10) ? b_rdata : a_rdata), 32'(exp_data[ndone-1]));
                ndone++;
                if (ndone == 4) begin
                    a_req = 1'b0;
                    b_req = 1'b0;
                end
            end
        end
        check("t2 four dones", 32'(ndone), 32'd4);
        a_req = 1'b0; b_req = 1'b0;

        // ---- urgent refresh under continuous load ----
        do_reset();
        rst = 1'b0; ready_en = 1'b1; rsp_delay = 1; track = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        step(120);
        check("t3 max pending",       32'(max_pend),        32'd4);
        check("t3 urgent not first",  32'(urg_bad),         32'd0);
        check("t3 urgent refresh seen", 32'(urg_hits > 0),  32'd1);
        check("t3 pending model",     32'(pend_err),        32'd0);
        a_req = 1'b0; b_req = 1'b0; track = 1'b0;

        // ---- saturation and drain ----
        do_reset();
        rst = 1'b0; ready_en = 1'b0;
        step(200);
        check("t4 pending sat",  32'(refresh_pending),  32'd15);
        check("t4 overflow",     32'(refresh_overflow), 32'd1);
        ready_en = 1'b1;
        found = 1'b0;
        for (int i = 0; (i < 200) && !found; i++) begin
            step(1);
            if (refresh_pending < 4'd4) found = 1'b1;
        end
        check("t4 drained below urgent", 32'(found),            32'd1);
        check("t4 overflow sticky",      32'(refresh_overflow), 32'd1);
        step(40);
        check("t4 tick+refresh coincide seen", 32'(coinc > 0), 32'd1);
        check("t4 pending model", 32'(pend_err), 32'd0);
        if (pend_err != 0)
            $display("note: last refresh count disagreement observed %0d expected %0d", err_obs, err_exp);

        // ---- reset during ISSUE ----
        do_reset();
        rst = 1'b0; ready_en = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 24'h000055;
        step(1);
        check("t5 valid before rst", 32'(mem_cmd_valid), 32'd1);
        snap_a_ack = n_a_ack; snap_a_done = n_a_done; snap_b_ack = n_b_ack; snap_b_done = n_b_done;
        rst = 1'b1; a_req = 1'b0;
        step(1);
        check("t5 valid after rst", 32'(mem_cmd_valid), 32'd0);
        check("t5 no ack",          32'(a_ack),         32'd0);
        rst = 1'b0;
        inject_req++;
        step(1);
        check("t5 late rsp no a_done", 32'(a_done),  32'd0);
        check("t5 late rsp no b_done", 32'(b_done),  32'd0);
        check("t5 late rsp no rdata",  32'(a_rdata), 32'd0);
        ready_en = 1'b1; rsp_delay = 1;
        a_req = 1'b1; a_addr = 24'h0000A5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 24'h0000B5;
        step(1);
        check("t5 tie valid", 32'(mem_cmd_valid), 32'd1);
        check("t5 tie A wins", 32'(mem_cmd_addr), 32'h0000A5);
        step(1);
        check("t5 a_ack", 32'(a_ack), 32'd1);
        check("t5 b idle", 32'(b_ack), 32'd0);
        a_req = 1'b0;
        found = 1'b0;
        for (int i = 0; (i < 20) && !found; i++) begin
            step(1);
            if (b_ack) found = 1'b1;
        end
        check("t5 b granted", 32'(found), 32'd1);
        b_req = 1'b0;
        step(6);
        check("t5 a_ack count",  32'(n_a_ack - snap_a_ack),   32'd1);
        check("t5 a_done count", 32'(n_a_done - snap_a_done), 32'd1);
        check("t5 b_done count", 32'(n_b_done - snap_b_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
